izh_spike_encoder: RTL and testbench

- Downstream stage of the Izhikevich neuron core.
- Consumes the neuron's 8-bit signed membrane-potential sample (top 8 bits of the 2.16 state, 2.6 format).
- Detects spikes with hysteresis and emits a one-cycle spike pulse.
- Measures inter-spike intervals (ISI) in enabled cycles and buffers them in a small FIFO, drained over a valid/ready handshake by the readout logic.

---
 rtl/izh_spike_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_izh_spike_encoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izh_spike_encoder.sv
// izh_spike_encoder: hysteretic spike detector, inter-spike-interval counter and show-ahead ISI FIFO.
// Define SPIKE_RATE_EN to add the windowed spike-rate counter on rate_o/rate_valid.
module izh_spike_encoder #(
  parameter int ISI_W   = 12,
  parameter int DEPTH   = 8,
  parameter int WIN_LEN = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     clr,
  input  logic signed [7:0]        v_in,
  input  logic signed [7:0]        thr_hi,
  input  logic signed [7:0]        thr_lo,
  output logic                     spike_o,
  output logic [ISI_W-1:0]         isi_data,
  output logic                     isi_valid,
  input  logic                     isi_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               rate_o,
  output logic                     rate_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [AW:0]      FULL_LVL = (AW + 1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("izh_spike_encoder: DEPTH must be a power of 2, minimum 2");
  end
  if (WIN_LEN < 1) begin : g_win_check
    $error("izh_spike_encoder: WIN_LEN must be at least 1");
  end

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             spike_det;
  logic [ISI_W-1:0] cnt;
  logic [ISI_W-1:0] cnt_inc;
  logic             first_seen;

  logic [ISI_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             full;
  logic             push_req;
  logic             do_push;
  logic             do_pop;

  // ---------------------------------------------------------------------------
  // Hysteresis FSM: fire above thr_hi, re-arm only once below thr_lo.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARMED;
    end else if (clr) begin
      state <= ARMED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_nxt = state;
    spike_det = 1'b0;
    if (ena) begin
      unique case (state)
        ARMED: begin
          if (v_in > thr_hi) begin
            spike_det = 1'b1;
            state_nxt = FIRED;
          end
        end
        FIRED: begin
          if (v_in < thr_lo) begin
            state_nxt = ARMED;
          end
        end
        default: state_nxt = ARMED;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ISI counter; the interval reported on a spike includes the spike cycle.
  // ---------------------------------------------------------------------------
  assign cnt_inc = (cnt == ISI_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      first_seen <= 1'b0;
      spike_o    <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      first_seen <= 1'b0;
      spike_o    <= 1'b0;
    end else begin
      spike_o <= spike_det;
      if (ena) begin
        if (spike_det) begin
          cnt        <= '0;
          first_seen <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ISI FIFO: a full FIFO still accepts a push when a pop happens the same edge.
  // ---------------------------------------------------------------------------
  assign full     = (level == FULL_LVL);
  assign push_req = spike_det && first_seen;
  assign do_pop   = !clr && isi_valid && isi_ready;
  assign do_push  = !clr && push_req && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_req && full && !do_pop) overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; isi_data is masked while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= cnt_inc;
  end

  assign isi_valid  = (level != '0);
  assign isi_data   = isi_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

`ifdef SPIKE_RATE_EN
  // ---------------------------------------------------------------------------
  // Spike-rate window: count spikes over WIN_LEN enabled cycles.
  // ---------------------------------------------------------------------------
  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);

  logic [WW-1:0] win_cnt;
  logic [7:0]    spk_cnt;
  logic [7:0]    spk_sum;

  assign spk_sum = (spike_det && (spk_cnt != 8'hFF)) ? spk_cnt + 8'd1 : spk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      spk_cnt    <= '0;
      rate_o     <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (clr) begin
        win_cnt <= '0;
        spk_cnt <= '0;
      end else if (ena) begin
        if (win_cnt == WIN_LAST) begin
          rate_o     <= spk_sum;
          rate_valid <= 1'b1;
          win_cnt    <= '0;
          spk_cnt    <= '0;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          spk_cnt <= spk_sum;
        end
      end
    end
  end
`else
  assign rate_o     = '0;
  assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_izh_spike_encoder.sv
// Self-checking bench for izh_spike_encoder: directed stimulus, ISI scoreboard drained by a monitor.
module tb_izh_spike_encoder;

  localparam int ISI_W   = 4;
  localparam int DEPTH   = 8;
  localparam int WIN_LEN = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             clr = 1'b0;
  logic [7:0]       v_in = 8'h00;
  logic [7:0]       thr_hi = 8'h13;
  logic [7:0]       thr_lo = 8'hD0;
  logic             spike_o;
  logic [ISI_W-1:0] isi_data;
  logic             isi_valid;
  logic             isi_ready = 1'b0;
  logic [LW-1:0]    fifo_level;
  logic             overflow;
  logic [7:0]       rate_o;
  logic             rate_valid;

  izh_spike_encoder #(
    .ISI_W   (ISI_W),
    .DEPTH   (DEPTH),
    .WIN_LEN (WIN_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .clr        (clr),
    .v_in       (v_in),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .spike_o    (spike_o),
    .isi_data   (isi_data),
    .isi_valid  (isi_valid),
    .isi_ready  (isi_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .rate_o     (rate_o),
    .rate_valid (rate_valid)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               spikes_seen = 0;
  int               rv_cnt = 0;
  logic [ISI_W-1:0] exp_q [$];
  logic [7:0]       pat [16] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h20, 8'hC0, 8'hC0, 8'hC0,
                                 8'hC0, 8'h20, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h20, 8'hC0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive n cycles of v with the given enable, sampling 1 time unit after each edge.
  task automatic apply(input logic [7:0] v, input int n, input logic e = 1'b1);
    for (int i = 0; i < n; i++) begin
      v_in = v;
      ena  = e;
      @(posedge clk);
      #1;
      if (spike_o) spikes_seen++;
      if (rate_valid) rv_cnt++;
    end
  endtask

  // Re-arm for k cycles then spike: ISI = k + 1 when starting from a just-fired state.
  task automatic pair(input int k);
    apply(8'hC0, k);
    apply(8'h20, 1);
  endtask

  // Scoreboard monitor: every accepted head entry is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && isi_valid && isi_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL isi_pop: got %0d expected no entry (t=%0t)", isi_data, $time);
      end else begin
        check("isi_pop", 32'(isi_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_spike", 32'(spike_o), 0);
    check("rst_valid", 32'(isi_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_data", 32'(isi_data), 0);
    check("rst_rate", 32'(rate_o), 0);
    check("rst_rate_valid", 32'(rate_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sequence: first spike unpushed, second spike reports ISI 10.
    spikes_seen = 0;
    apply(8'hD3, 5);
    check("t1_quiet", 32'(spikes_seen), 0);
    apply(8'h14, 1);
    check("t1_spike1", 32'(spike_o), 1);
    check("t1_first_not_pushed", 32'(fifo_level), 0);
    apply(8'hC0, 9);
    check("t1_one_spike", 32'(spikes_seen), 1);
    apply(8'h14, 1);
    exp_q.push_back(4'd10);
    check("t1_spike2", 32'(spike_o), 1);
    check("t1_valid", 32'(isi_valid), 1);
    check("t1_isi", 32'(isi_data), 10);
    check("t1_level", 32'(fifo_level), 1);
    apply(8'h14, 1);
    check("t1_pulse_width", 32'(spike_o), 0);

    // Hysteresis: no re-fire without dropping below thr_lo; ISI saturates at 15.
    spikes_seen = 0;
    apply(8'h00, 20);
    apply(8'h20, 1);
    check("t2_no_refire", 32'(spikes_seen), 0);
    apply(8'hC0, 1);
    apply(8'h20, 1);
    exp_q.push_back(4'd15);
    check("t2_refire", 32'(spike_o), 1);
    check("t2_level", 32'(fifo_level), 2);
    isi_ready = 1'b1;
    apply(8'h20, 3, 1'b0);
    isi_ready = 1'b0;
    check("t2_drained", 32'(fifo_level), 0);

    // Fill and overflow: ISIs 2..11, the last two are dropped.
    for (int i = 0; i < 10; i++) begin
      pair(i + 1);
      if (i < 8) exp_q.push_back(ISI_W'(i + 2));
      if (i == 7) begin
        check("t3_full_level", 32'(fifo_level), 8);
        check("t3_full_no_ovf", 32'(overflow), 0);
      end
    end
    check("t3_level_after_drop", 32'(fifo_level), 8);
    check("t3_overflow", 32'(overflow), 1);
    isi_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply(8'h20, 1, 1'b0);
      check("t3_drain_level", 32'(fifo_level), 32'(7 - i));
    end
    isi_ready = 1'b0;
    check("t3_empty", 32'(isi_valid), 0);
    check("t3_ovf_sticky", 32'(overflow), 1);
    clr = 1'b1;
    apply(8'h20, 1, 1'b0);
    clr = 1'b0;
    check("t3_clr_level", 32'(fifo_level), 0);
    check("t3_clr_ovf", 32'(overflow), 0);

    // Simultaneous push and pop while full.
    apply(8'h20, 1);
    check("t4_first_spike", 32'(spike_o), 1);
    check("t4_first_not_pushed", 32'(fifo_level), 0);
    for (int i = 0; i < 8; i++) begin
      pair(i + 1);
      exp_q.push_back(ISI_W'(i + 2));
    end
    check("t4_full", 32'(fifo_level), 8);
    apply(8'hC0, 3);
    isi_ready = 1'b1;
    apply(8'h20, 1);
    isi_ready = 1'b0;
    exp_q.push_back(4'd4);
    check("t4_pushpop_spike", 32'(spike_o), 1);
    check("t4_pushpop_level", 32'(fifo_level), 8);
    check("t4_pushpop_no_ovf", 32'(overflow), 0);
    isi_ready = 1'b1;
    apply(8'h20, 9, 1'b0);
    isi_ready = 1'b0;
    check("t4_drained", 32'(fifo_level), 0);

    // ena=0 gaps hold the counter; 40 enabled cycles saturate.
    spikes_seen = 0;
    apply(8'hC0, 1);
    apply(8'h20, 30, 1'b0);
    check("t5_no_spike_disabled", 32'(spikes_seen), 0);
    apply(8'hC0, 5);
    apply(8'h20, 1);
    exp_q.push_back(4'd7);
    check("t5_gap_isi", 32'(isi_data), 7);
    apply(8'hC0, 39);
    apply(8'h20, 1);
    exp_q.push_back(4'd15);
    check("t5_sat_level", 32'(fifo_level), 2);
    isi_ready = 1'b1;
    apply(8'h20, 3, 1'b0);
    isi_ready = 1'b0;
    check("t5_drained", 32'(fifo_level), 0);

    // clr mid-operation with three queued entries and the FSM fired.
    for (int i = 0; i < 3; i++) begin
      pair(i + 1);
      exp_q.push_back(ISI_W'(i + 2));
    end
    check("t6_level3", 32'(fifo_level), 3);
    clr = 1'b1;
    apply(8'h20, 1);
    clr = 1'b0;
    exp_q.delete();
    check("t6_clr_level", 32'(fifo_level), 0);
    check("t6_clr_valid", 32'(isi_valid), 0);
    check("t6_clr_ovf", 32'(overflow), 0);
    check("t6_clr_spike", 32'(spike_o), 0);
    apply(8'h20, 1);
    check("t6_rearmed_spike", 32'(spike_o), 1);
    check("t6_not_pushed", 32'(fifo_level), 0);
    apply(8'hC0, 1);
    clr = 1'b1;
    apply(8'h20, 1);
    clr = 1'b0;
    check("t6_clr_beats_spike", 32'(spike_o), 0);
    apply(8'h20, 1);
    check("t6_spike_after_clr", 32'(spike_o), 1);
    check("t6_first_again", 32'(fifo_level), 0);
    pair(1);
    exp_q.push_back(4'd2);
    check("t6_push_level", 32'(fifo_level), 1);
    check("t6_push_isi", 32'(isi_data), 2);

    // Asynchronous reset mid-cycle with a spike pulse and entries pending.
    apply(8'hC0, 1);
    apply(8'h20, 1);
    check("t7_pre_spike", 32'(spike_o), 1);
    check("t7_pre_level", 32'(fifo_level), 2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t7_async_spike", 32'(spike_o), 0);
    check("t7_async_level", 32'(fifo_level), 0);
    check("t7_async_valid", 32'(isi_valid), 0);
    check("t7_async_data", 32'(isi_data), 0);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Two 16-cycle windows with three spikes each.
    spikes_seen = 0;
    rv_cnt      = 0;
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 16; j++) begin
        apply(pat[j], 1);
`ifdef SPIKE_RATE_EN
        if (j == 15) begin
          check("t8_rate_valid", 32'(rate_valid), 1);
          check("t8_rate", 32'(rate_o), 3);
        end
`endif
      end
    end
    check("t8_spikes", 32'(spikes_seen), 6);
`ifdef SPIKE_RATE_EN
    check("t8_rate_pulses", 32'(rv_cnt), 2);
`else
    check("t8_rate_off", 32'(rate_o), 0);
    check("t8_rate_pulses_off", 32'(rv_cnt), 0);
`endif
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd5);
    check("t8_level", 32'(fifo_level), 5);
    isi_ready = 1'b1;
    apply(8'h20, 6, 1'b0);
    isi_ready = 1'b0;
    check("t8_drained", 32'(fifo_level), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
